axi_sram_slave: RTL



---
 rtl/axi_sram_slave_if.sv | 65 ++++++
 rtl/axi_sram_slave.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI4 slave-side bus bundle for the single-port SRAM slave.
// One write path (AW/W/B) and one read path (AR/R), 28-bit byte addresses.
interface axi_sram_slave_if #(
  parameter int ID_WIDTH = 5
);
  logic [ID_WIDTH-1:0] s_awid;
  logic [27:0]         s_awaddr;
  logic [7:0]          s_awlen;
  logic [2:0]          s_awsize;
  logic [1:0]          s_awburst;
  logic                s_awvalid;
  logic                s_awready;

  logic [31:0]         s_wdata;
  logic [3:0]          s_wstrb;
  logic                s_wlast;
  logic                s_wvalid;
  logic                s_wready;

  logic [ID_WIDTH-1:0] s_bid;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  logic [ID_WIDTH-1:0] s_arid;
  logic [27:0]         s_araddr;
  logic [7:0]          s_arlen;
  logic [2:0]          s_arsize;
  logic [1:0]          s_arburst;
  logic                s_arvalid;
  logic                s_arready;

  logic [ID_WIDTH-1:0] s_rid;
  logic [31:0]         s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic                s_rvalid;
  logic                s_rready;

  modport slave (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a 2^MEM_AW x 32-bit SRAM, one burst in flight,
// round-robin arbitration between read and write address channels.
module axi_sram_slave #(
  parameter int MEM_AW   = 14,
  parameter int ID_WIDTH = 5
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_sram_slave_if.slave   s_axi
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WDATA, WRESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_lastWrite;
  logic [ID_WIDTH-1:0] r_id;
  logic [27:0]         r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [8:0]          r_cnt;
  logic                r_err;
  logic                r_burstErr;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [2**MEM_AW];

  logic                w_arGrant;
  logic                w_awGrant;
  logic                w_rlast;
  logic                w_memWe;
  logic [27:0]         w_nextAddr;
  logic [MEM_AW-1:0]   w_wordIdx;

  function automatic logic [27:0] advanceAddr(input logic [27:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
    logic [27:0] inc;
    logic [27:0] sum;
    logic [27:0] mask;
    logic [27:0] res;
    inc  = 28'd1 << size;
    sum  = addr + inc;
    mask = (({20'd0, len} + 28'd1) << size) - 28'd1;
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (addr & ~mask) | (sum & mask);
      default: res = sum;
    endcase
    return res;
  endfunction

  function automatic logic badBurst(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) ||
           ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  // Read wins a tie only when the previous grant went to the write side.
  assign w_arGrant  = s_axi.s_arvalid && (!s_axi.s_awvalid || r_lastWrite);
  assign w_awGrant  = s_axi.s_awvalid && !w_arGrant;
  assign w_rlast    = (r_cnt == {1'b0, r_len});
  assign w_nextAddr = advanceAddr(r_addr, r_size, r_len, r_burst);
  assign w_wordIdx  = r_addr[MEM_AW+1:2];
  assign w_memWe    = aresetn && (r_state == WDATA) && s_axi.s_wvalid &&
                      (r_cnt <= {1'b0, r_len}) && !r_burstErr;

  always_comb begin
    w_next            = r_state;
    s_axi.s_arready   = 1'b0;
    s_axi.s_awready   = 1'b0;
    s_axi.s_wready    = 1'b0;
    s_axi.s_bvalid    = 1'b0;
    s_axi.s_bid       = '0;
    s_axi.s_bresp     = 2'b00;
    s_axi.s_rvalid    = 1'b0;
    s_axi.s_rid       = '0;
    s_axi.s_rdata     = '0;
    s_axi.s_rresp     = 2'b00;
    s_axi.s_rlast     = 1'b0;
    if (aresetn) begin
      case (r_state)
        IDLE: begin
          s_axi.s_arready = w_arGrant;
          s_axi.s_awready = w_awGrant;
          if (w_arGrant)      w_next = RADDR;
          else if (w_awGrant) w_next = WDATA;
        end
        RADDR: w_next = RDATA;
        RDATA: begin
          s_axi.s_rvalid = 1'b1;
          s_axi.s_rid    = r_id;
          s_axi.s_rdata  = r_rdata;
          s_axi.s_rresp  = r_burstErr ? 2'b10 : 2'b00;
          s_axi.s_rlast  = w_rlast;
          if (s_axi.s_rready) w_next = w_rlast ? IDLE : RADDR;
        end
        WDATA: begin
          s_axi.s_wready = 1'b1;
          if (s_axi.s_wvalid && s_axi.s_wlast) w_next = WRESP;
        end
        WRESP: begin
          s_axi.s_bvalid = 1'b1;
          s_axi.s_bid    = r_id;
          s_axi.s_bresp  = (r_err || r_burstErr) ? 2'b10 : 2'b00;
          if (s_axi.s_bready) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_lastWrite <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_burstErr  <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_arGrant) begin
            r_lastWrite <= 1'b0;
            r_id        <= s_axi.s_arid;
            r_addr      <= s_axi.s_araddr;
            r_len       <= s_axi.s_arlen;
            r_size      <= s_axi.s_arsize;
            r_burst     <= s_axi.s_arburst;
            r_burstErr  <= badBurst(s_axi.s_arburst, s_axi.s_arlen);
            r_cnt       <= '0;
          end else if (w_awGrant) begin
            r_lastWrite <= 1'b1;
            r_id        <= s_axi.s_awid;
            r_addr      <= s_axi.s_awaddr;
            r_len       <= s_axi.s_awlen;
            r_size      <= s_axi.s_awsize;
            r_burst     <= s_axi.s_awburst;
            r_burstErr  <= badBurst(s_axi.s_awburst, s_axi.s_awlen);
            r_cnt       <= '0;
            r_err       <= 1'b0;
          end
        end
        RADDR: r_rdata <= r_burstErr ? 32'd0 : r_mem[w_wordIdx];
        RDATA: begin
          if (s_axi.s_rready && !w_rlast) begin
            r_addr <= w_nextAddr;
            r_cnt  <= r_cnt + 9'd1;
          end
        end
        WDATA: begin
          if (s_axi.s_wvalid) begin
            r_addr <= w_nextAddr;
            if (r_cnt != 9'h1FF) r_cnt <= r_cnt + 9'd1;
            if ((s_axi.s_wlast && !w_rlast) || (r_cnt > {1'b0, r_len})) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset so contents survive an aresetn pulse.
  always_ff @(posedge aclk) begin
    if (w_memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.s_wstrb[b]) r_mem[w_wordIdx][8*b +: 8] <= s_axi.s_wdata[8*b +: 8];
      end
    end
  end

endmodule
